generation_scheduler: RTL

Sequences the `Iterator` mutation datapath across successive generations of the genetic search.
- Each generation:
  - launches `Iterator` with the current parent and a per-generation seed;
  - captures the 5-child family;
  - scores each child through a request/acknowledge fitness port;
  - promotes the best-scoring child to parent (elitist: the parent is kept unless a child strictly beats it).
- Sits between the top-level run control and the `Iterator` / fitness evaluator pair.

---
 rtl/ga_pkg.sv | 11 +
 rtl/seed_lfsr.sv | 11 +
 rtl/generation_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// ga_pkg: shared widths, LFSR taps and scheduler state encoding
package ga_pkg;
  localparam int GENOME_W = 150;
  localparam int FAMILY_N = 5;
  localparam int SCORE_W = 16;
  localparam int SEED_W = 32;
  localparam int GEN_W = 16;
  localparam int IDX_W = $clog2(FAMILY_N);
  localparam logic [SEED_W-1:0] LFSR_TAPS = 32'h80200003;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ITER, EVAL, UPDATE, DONE} state_e;
endpackage

// File: rtl/seed_lfsr.sv
// seed_lfsr: one-step Galois advance, or a zero-guarded load of the initial seed
module seed_lfsr import ga_pkg::*; (
  input  logic              load_i,
  input  logic [SEED_W-1:0] init_i,
  input  logic [SEED_W-1:0] seed_i,
  output logic [SEED_W-1:0] seed_o
);
  // an all-zero seed would lock the LFSR, so it is replaced by 1
  always_comb seed_o = load_i ? ((init_i == '0) ? SEED_W'(1) : init_i)
                              : ((seed_i >> 1) ^ (seed_i[0] ? LFSR_TAPS : '0));
endmodule

// File: rtl/generation_scheduler.sv
// generation_scheduler: runs Iterator + fitness evaluation per generation, keeping the elitist best parent
module generation_scheduler import ga_pkg::*; (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [GEN_W-1:0]             max_gens,
  input  logic [GENOME_W-1:0]          init_parent,
  input  logic [SEED_W-1:0]            init_seed,
  output logic                         iter_start,
  output logic [GENOME_W-1:0]          iter_parent,
  output logic [SEED_W-1:0]            iter_seed,
  input  logic [GENOME_W*FAMILY_N-1:0] iter_family,
  input  logic                         iter_done,
  output logic                         fit_req,
  output logic [GENOME_W-1:0]          fit_genome,
  input  logic                         fit_ack,
  input  logic [SCORE_W-1:0]           fit_score,
  output logic [GENOME_W-1:0]          best_parent,
  output logic [SCORE_W-1:0]           best_score,
  output logic [GEN_W-1:0]             gen_count,
  output logic                         busy,
  output logic                         finished
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FAMILY_N - 1);
  state_e state_q, state_d;
  logic [GENOME_W-1:0] parent_q;
  logic [GENOME_W-1:0] family_q [FAMILY_N];
  logic [SEED_W-1:0] seed_q, seed_nx;
  logic [SCORE_W-1:0] best_q, gmax_q;
  logic [GEN_W-1:0] gen_q, max_q, gen_inc;
  logic [IDX_W-1:0] idx_q, widx_q;
  logic won_q, fin_q;

  seed_lfsr u_lfsr (
    .load_i(state_q == IDLE),
    .init_i(init_seed),
    .seed_i(seed_q),
    .seed_o(seed_nx)
  );

  assign gen_inc = gen_q + 1'b1;
  assign iter_start = state_q == LAUNCH;
  assign fit_req = state_q == EVAL;
  assign fit_genome = family_q[idx_q];
  assign iter_parent = parent_q;
  assign best_parent = parent_q;
  assign iter_seed = seed_q;
  assign best_score = best_q;
  assign gen_count = gen_q;
  assign busy = !(state_q == IDLE || state_q == DONE);
  assign finished = fin_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (run) state_d = (max_gens == '0) ? DONE : LAUNCH;
      LAUNCH:    state_d = WAIT_ITER;
      WAIT_ITER: if (iter_done) state_d = EVAL;
      EVAL:      if (fit_ack && idx_q == LAST) state_d = UPDATE;
      UPDATE:    state_d = (gen_inc == max_q) ? DONE : LAUNCH;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      parent_q <= '0;
      seed_q <= '0;
      best_q <= '0;
      gmax_q <= '0;
      gen_q <= '0;
      max_q <= '0;
      idx_q <= '0;
      widx_q <= '0;
      won_q <= 1'b0;
      fin_q <= 1'b0;
      for (int k = 0; k < FAMILY_N; k++) family_q[k] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (run) begin
          parent_q <= init_parent;
          seed_q <= seed_nx;
          best_q <= '0;
          gen_q <= '0;
          max_q <= max_gens;
          fin_q <= 1'b0;
        end
        WAIT_ITER: if (iter_done) begin
          for (int k = 0; k < FAMILY_N; k++) family_q[k] <= iter_family[k*GENOME_W +: GENOME_W];
          idx_q <= '0;
          gmax_q <= best_q;
          won_q <= 1'b0;
        end
        // strict compare: ties keep the earlier candidate, the parent first of all
        EVAL: if (fit_ack) begin
          if (fit_score > gmax_q) begin
            gmax_q <= fit_score;
            widx_q <= idx_q;
            won_q <= 1'b1;
          end
          idx_q <= idx_q + 1'b1;
        end
        UPDATE: begin
          if (won_q) begin
            parent_q <= family_q[widx_q];
            best_q <= gmax_q;
          end
          seed_q <= seed_nx;
          gen_q <= gen_inc;
        end
        DONE: fin_q <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule
